// File: rtl/keylock_ctrl.sv
// -----------------------------------------------------------------------------
// keylock_ctrl
// Keypad combination lock controller. Collects four BCD digits from a keypad
// scanner, compares them against CODE, and drives an external LED pattern
// generator to signal success, failure or lockout. After MAX_FAIL consecutive
// failures the lock enters a timed lockout with the alarm raised.
//
// Ports
//   hwclk        in   1   sole clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   button       in   4   key code: 0-9 digit, 10 clear, 11 lock, 12-15 invalid
//   bstate       in   1   key-held level from the scanner
//   pat_enable   out  1   pattern request, held until pat_done is seen
//   pat_ontime   out  32  pattern on-time in cycles
//   pat_offtime  out  32  pattern off-time in cycles
//   pat_reps     out  8   pattern repetition count
//   pat_done     in   1   pattern complete (ignored while pat_enable is low)
//   unlocked     out  1   lock released
//   alarm        out  1   lockout active
//   entry_cnt    out  3   digits entered so far (0..4)
// -----------------------------------------------------------------------------
module keylock_ctrl #(
    parameter logic [15:0] CODE          = 16'h1234,
    parameter int unsigned CLK_HZ        = 12000000,
    parameter int unsigned MAX_FAIL      = 3,
    parameter int unsigned ENTRY_TIMEOUT = 60000000,
    parameter int unsigned RELOCK_CYC    = 120000000,
    parameter int unsigned LOCKOUT_CYC   = 360000000
) (
    input  logic        hwclk,
    input  logic        rst,
    input  logic [3:0]  button,
    input  logic        bstate,
    output logic        pat_enable,
    output logic [31:0] pat_ontime,
    output logic [31:0] pat_offtime,
    output logic [7:0]  pat_reps,
    input  logic        pat_done,
    output logic        unlocked,
    output logic        alarm,
    output logic [2:0]  entry_cnt
);

    // FSM encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ENTRY     = 3'd1;
    localparam logic [2:0] ST_CHECK     = 3'd2;
    localparam logic [2:0] ST_SHOW_OK   = 3'd3;
    localparam logic [2:0] ST_UNLOCKED  = 3'd4;
    localparam logic [2:0] ST_SHOW_FAIL = 3'd5;
    localparam logic [2:0] ST_LOCKOUT   = 3'd6;

    localparam logic [3:0] KEY_CLEAR = 4'd10;
    localparam logic [3:0] KEY_LOCK  = 4'd11;

    localparam logic [31:0] OK_TIME   = 32'(CLK_HZ / 4);
    localparam logic [31:0] FAIL_TIME = 32'(CLK_HZ / 2);
    localparam logic [31:0] LOCK_TIME = 32'(CLK_HZ / 8);

    // The timer holds 0 in the first cycle of a state, so a state that must
    // last N cycles exits when the timer reads N-1.
    localparam logic [31:0] ENTRY_LAST   = (ENTRY_TIMEOUT > 0) ? 32'(ENTRY_TIMEOUT - 1) : 32'd0;
    localparam logic [31:0] RELOCK_LAST  = (RELOCK_CYC > 0)    ? 32'(RELOCK_CYC - 1)    : 32'd0;
    localparam logic [31:0] LOCKOUT_LAST = (LOCKOUT_CYC > 0)   ? 32'(LOCKOUT_CYC - 1)   : 32'd0;
    localparam logic [2:0]  MAX_FAIL_C   = 3'(MAX_FAIL);
    localparam logic [31:0] TIMER_MAX    = 32'hFFFF_FFFF;

    logic        bstate_q;
    logic [2:0]  state_q,    state_d;
    logic [15:0] entry_q,    entry_d;
    logic [2:0]  cnt_q,      cnt_d;
    logic [2:0]  fail_cnt_q, fail_cnt_d;
    logic [31:0] timer_q,    timer_d;
    logic        pat_en_q,   pat_en_d;
    logic [31:0] pat_time_q, pat_time_d;
    logic [7:0]  pat_reps_q, pat_reps_d;
    logic        unlocked_q, unlocked_d;
    logic        alarm_q,    alarm_d;

    logic        press_s;
    logic        digit_s;
    logic        clear_s;
    logic        lock_s;
    logic        timer_kick_s;
    logic [2:0]  fail_inc_s;
    logic [15:0] entry_shift_s;

    // Key press is the rising edge of bstate; the registered copy resets to 1
    // so a key held through reset is not seen as a press.
    assign press_s       = bstate & ~bstate_q;
    assign digit_s       = press_s & (button <= 4'd9);
    assign clear_s       = press_s & (button == KEY_CLEAR);
    assign lock_s        = press_s & (button == KEY_LOCK);
    assign fail_inc_s    = fail_cnt_q + 3'd1;
    assign entry_shift_s = {entry_q[11:0], button};

    // Next-state logic for the lock FSM, entry register and failure counter
    always_comb begin
        state_d      = state_q;
        entry_d      = entry_q;
        cnt_d        = cnt_q;
        fail_cnt_d   = fail_cnt_q;
        timer_kick_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (digit_s) begin
                    entry_d = entry_shift_s;
                    cnt_d   = cnt_q + 3'd1;
                    state_d = ST_ENTRY;
                end else if (clear_s) begin
                    entry_d = 16'h0000;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                if (digit_s) begin
                    entry_d      = entry_shift_s;
                    cnt_d        = cnt_q + 3'd1;
                    timer_kick_s = 1'b1;
                    // The fourth digit goes straight to the compare cycle.
                    if (cnt_q == 3'd3) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_ENTRY;
                    end
                end else if (clear_s || (timer_q >= ENTRY_LAST)) begin
                    entry_d = 16'h0000;
                    cnt_d   = 3'd0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ENTRY;
                end
            end
            ST_CHECK: begin
                entry_d = 16'h0000;
                cnt_d   = 3'd0;
                if (entry_q == CODE) begin
                    fail_cnt_d = 3'd0;
                    state_d    = ST_SHOW_OK;
                end else begin
                    fail_cnt_d = fail_inc_s;
                    if (fail_inc_s == MAX_FAIL_C) begin
                        state_d = ST_LOCKOUT;
                    end else begin
                        state_d = ST_SHOW_FAIL;
                    end
                end
            end
            ST_SHOW_OK: begin
                if (pat_en_q && pat_done) begin
                    state_d = ST_UNLOCKED;
                end else begin
                    state_d = ST_SHOW_OK;
                end
            end
            ST_SHOW_FAIL: begin
                if (pat_en_q && pat_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SHOW_FAIL;
                end
            end
            ST_UNLOCKED: begin
                if (lock_s || (timer_q >= RELOCK_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_UNLOCKED;
                end
            end
            ST_LOCKOUT: begin
                // Lockout ends on time alone; pat_done only drops the request.
                if (timer_q >= LOCKOUT_LAST) begin
                    fail_cnt_d = 3'd0;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_LOCKOUT;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                entry_d    = 16'h0000;
                cnt_d      = 3'd0;
                fail_cnt_d = 3'd0;
            end
        endcase
    end

    // State timer: zero on state entry or accepted digit, otherwise saturating count
    always_comb begin
        if ((state_d != state_q) || timer_kick_s) begin
            timer_d = 32'd0;
        end else if (timer_q != TIMER_MAX) begin
            timer_d = timer_q + 32'd1;
        end else begin
            timer_d = timer_q;
        end
    end

    // Pattern request: raised on entry to a pattern state, dropped once pat_done is seen
    always_comb begin
        if (state_d != state_q) begin
            pat_en_d = (state_d == ST_SHOW_OK) || (state_d == ST_SHOW_FAIL) ||
                       (state_d == ST_LOCKOUT);
        end else if (pat_en_q && pat_done) begin
            pat_en_d = 1'b0;
        end else begin
            pat_en_d = pat_en_q;
        end
    end

    // Pattern parameters and status flags follow the upcoming state so they are registered in step with it
    always_comb begin
        case (state_d)
            ST_SHOW_OK: begin
                pat_time_d = OK_TIME;
                pat_reps_d = 8'd2;
            end
            ST_SHOW_FAIL: begin
                pat_time_d = FAIL_TIME;
                pat_reps_d = 8'd3;
            end
            ST_LOCKOUT: begin
                pat_time_d = LOCK_TIME;
                pat_reps_d = 8'd255;
            end
            default: begin
                pat_time_d = 32'd0;
                pat_reps_d = 8'd0;
            end
        endcase
        unlocked_d = (state_d == ST_UNLOCKED);
        alarm_d    = (state_d == ST_LOCKOUT);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            bstate_q   <= 1'b1;
            state_q    <= ST_IDLE;
            entry_q    <= 16'h0000;
            cnt_q      <= 3'd0;
            fail_cnt_q <= 3'd0;
            timer_q    <= 32'd0;
            pat_en_q   <= 1'b0;
            pat_time_q <= 32'd0;
            pat_reps_q <= 8'd0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            bstate_q   <= bstate;
            state_q    <= state_d;
            entry_q    <= entry_d;
            cnt_q      <= cnt_d;
            fail_cnt_q <= fail_cnt_d;
            timer_q    <= timer_d;
            pat_en_q   <= pat_en_d;
            pat_time_q <= pat_time_d;
            pat_reps_q <= pat_reps_d;
            unlocked_q <= unlocked_d;
            alarm_q    <= alarm_d;
        end
    end

    assign pat_enable  = pat_en_q;
    assign pat_ontime  = pat_time_q;
    assign pat_offtime = pat_time_q;
    assign pat_reps    = pat_reps_q;
    assign unlocked    = unlocked_q;
    assign alarm       = alarm_q;
    assign entry_cnt   = cnt_q;

endmodule

// File: tb/tb_keylock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keylock_ctrl
// Bench for keylock_ctrl with small timing parameters: a hand-written vector
// table for the correct-code path, directed multi-cycle sequences, then
// randomized keypad traffic compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_keylock_ctrl;

    localparam logic [15:0] CODE     = 16'h1234;
    localparam int          CLK_HZ   = 800;
    localparam int          MAX_FAIL = 3;
    localparam int          ENTRY_TO = 20;
    localparam int          RELOCK   = 30;
    localparam int          LOCKOUT  = 40;

    logic        hwclk = 1'b0;
    logic        rst;
    logic [3:0]  button;
    logic        bstate;
    logic        pat_done;
    logic        pat_enable;
    logic [31:0] pat_ontime;
    logic [31:0] pat_offtime;
    logic [7:0]  pat_reps;
    logic        unlocked;
    logic        alarm;
    logic [2:0]  entry_cnt;

    keylock_ctrl #(
        .CODE(CODE), .CLK_HZ(CLK_HZ), .MAX_FAIL(MAX_FAIL),
        .ENTRY_TIMEOUT(ENTRY_TO), .RELOCK_CYC(RELOCK), .LOCKOUT_CYC(LOCKOUT)
    ) dut (
        .hwclk(hwclk), .rst(rst), .button(button), .bstate(bstate),
        .pat_enable(pat_enable), .pat_ontime(pat_ontime), .pat_offtime(pat_offtime),
        .pat_reps(pat_reps), .pat_done(pat_done), .unlocked(unlocked),
        .alarm(alarm), .entry_cnt(entry_cnt)
    );

    always #5 hwclk = ~hwclk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_COLLECT, M_VERIFY, M_OK_SHOW, M_FAIL_SHOW, M_OPEN, M_ALARM} mode_t;
    mode_t m_mode;
    int    m_digits[$];
    int    m_fails;
    int    m_age;
    bit    m_prev_b;
    bit    m_pat_on;

    function automatic int code_digit(input int i);
        logic [15:0] c;
        c = CODE;
        return int'((c >> (12 - 4 * i)) & 16'h000F);
    endfunction

    function automatic void model_reset();
        m_mode = M_COLLECT;
        m_digits.delete();
        m_fails  = 0;
        m_age    = 0;
        m_prev_b = 1'b1;
        m_pat_on = 1'b0;
    endfunction

    function automatic void model_step(input bit b, input int btn, input bit done);
        bit press;
        bit match;
        press    = b && !m_prev_b;
        m_prev_b = b;
        case (m_mode)
            M_COLLECT: begin
                if (press && btn < 10) begin
                    m_digits.push_back(btn);
                    m_age = 0;
                    if (m_digits.size() == 4) m_mode = M_VERIFY;
                end else if (press && btn == 10) begin
                    m_digits.delete();
                end else if (m_digits.size() > 0) begin
                    m_age++;
                    if (m_age >= ENTRY_TO) m_digits.delete();
                end
            end
            M_VERIFY: begin
                match = 1'b1;
                for (int i = 0; i < 4; i++) if (m_digits[i] != code_digit(i)) match = 1'b0;
                if (match) begin
                    m_fails = 0;
                    m_mode  = M_OK_SHOW;
                end else begin
                    m_fails++;
                    m_mode = (m_fails == MAX_FAIL) ? M_ALARM : M_FAIL_SHOW;
                end
                m_pat_on = 1'b1;
                m_age    = 0;
                m_digits.delete();
            end
            M_OK_SHOW: if (done) begin m_mode = M_OPEN; m_pat_on = 1'b0; m_age = 0; end
            M_FAIL_SHOW: if (done) begin m_mode = M_COLLECT; m_pat_on = 1'b0; end
            M_OPEN: begin
                if (press && btn == 11) begin
                    m_mode = M_COLLECT;
                end else begin
                    m_age++;
                    if (m_age >= RELOCK) m_mode = M_COLLECT;
                end
            end
            M_ALARM: begin
                if (done) m_pat_on = 1'b0;
                m_age++;
                if (m_age >= LOCKOUT) begin
                    m_mode   = M_COLLECT;
                    m_fails  = 0;
                    m_pat_on = 1'b0;
                end
            end
            default: m_mode = M_COLLECT;
        endcase
    endfunction

    task automatic model_check();
        int exp_reps;
        int exp_time;
        case (m_mode)
            M_OK_SHOW:   begin exp_reps = 2;   exp_time = CLK_HZ / 4; end
            M_FAIL_SHOW: begin exp_reps = 3;   exp_time = CLK_HZ / 2; end
            M_ALARM:     begin exp_reps = 255; exp_time = CLK_HZ / 8; end
            default:     begin exp_reps = 0;   exp_time = 0;          end
        endcase
        check("m_entry_cnt",   32'(entry_cnt),   32'(m_digits.size()));
        check("m_unlocked",    32'(unlocked),    32'(m_mode == M_OPEN));
        check("m_alarm",       32'(alarm),       32'(m_mode == M_ALARM));
        check("m_pat_enable",  32'(pat_enable),  32'(m_pat_on));
        check("m_pat_reps",    32'(pat_reps),    32'(exp_reps));
        check("m_pat_ontime",  pat_ontime,       32'(exp_time));
        check("m_pat_offtime", pat_offtime,      32'(exp_time));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic b, input logic [3:0] btn, input logic done);
        @(negedge hwclk);
        bstate   = b;
        button   = btn;
        pat_done = done;
        model_step(b, int'(btn), done);
        @(posedge hwclk);
        #1;
        model_check();
    endtask

    task automatic press(input logic [3:0] d);
        step(1'b1, d, 1'b0);
        step(1'b0, d, 1'b0);
    endtask

    task automatic do_reset(input logic held_b);
        @(negedge hwclk);
        rst      = 1'b1;
        bstate   = held_b;
        pat_done = 1'b0;
        model_reset();
        #1;
        check("rst_pat_enable", 32'(pat_enable), 32'd0);
        check("rst_pat_reps",   32'(pat_reps),   32'd0);
        check("rst_unlocked",   32'(unlocked),   32'd0);
        check("rst_entry_cnt",  32'(entry_cnt),  32'd0);
        @(negedge hwclk);
        rst = 1'b0;
        model_step(held_b, int'(button), 1'b0);
        @(posedge hwclk);
        #1;
        model_check();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        b;
        logic [3:0]  btn;
        logic        done;
        logic [2:0]  e_cnt;
        logic        e_unl;
        logic        e_pen;
        logic [7:0]  e_reps;
        logic [31:0] e_on;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int alarm_cycles;
        int open_cycles;
        logic cur_b;
        logic [3:0] btn;
        int r;

        tbl[0]  = '{1'b1, 4'd1,  1'b0, 3'd1, 1'b0, 1'b0, 8'd0, 32'd0};
        tbl[1]  = '{1'b0, 4'd1,  1'b0, 3'd1, 1'b0, 1'b0, 8'd0, 32'd0};
        tbl[2]  = '{1'b1, 4'd2,  1'b0, 3'd2, 1'b0, 1'b0, 8'd0, 32'd0};
        tbl[3]  = '{1'b0, 4'd2,  1'b0, 3'd2, 1'b0, 1'b0, 8'd0, 32'd0};
        tbl[4]  = '{1'b1, 4'd3,  1'b0, 3'd3, 1'b0, 1'b0, 8'd0, 32'd0};
        tbl[5]  = '{1'b0, 4'd3,  1'b0, 3'd3, 1'b0, 1'b0, 8'd0, 32'd0};
        tbl[6]  = '{1'b1, 4'd4,  1'b0, 3'd4, 1'b0, 1'b0, 8'd0, 32'd0};
        tbl[7]  = '{1'b0, 4'd4,  1'b0, 3'd0, 1'b0, 1'b1, 8'd2, 32'd200};
        tbl[8]  = '{1'b0, 4'd4,  1'b0, 3'd0, 1'b0, 1'b1, 8'd2, 32'd200};
        tbl[9]  = '{1'b0, 4'd4,  1'b1, 3'd0, 1'b1, 1'b0, 8'd0, 32'd0};
        tbl[10] = '{1'b0, 4'd4,  1'b0, 3'd0, 1'b1, 1'b0, 8'd0, 32'd0};
        tbl[11] = '{1'b1, 4'd11, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 32'd0};
        tbl[12] = '{1'b0, 4'd11, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 32'd0};

        rst = 1'b1; bstate = 1'b0; button = 4'd0; pat_done = 1'b0;
        do_reset(1'b0);

        // Correct code, unlock, manual lock
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].b, tbl[i].btn, tbl[i].done);
            check($sformatf("tbl%0d_entry_cnt", i), 32'(entry_cnt), 32'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_unlocked", i), 32'(unlocked), 32'(tbl[i].e_unl));
            check($sformatf("tbl%0d_pat_enable", i), 32'(pat_enable), 32'(tbl[i].e_pen));
            check($sformatf("tbl%0d_pat_reps", i), 32'(pat_reps), 32'(tbl[i].e_reps));
            check($sformatf("tbl%0d_pat_ontime", i), pat_ontime, tbl[i].e_on);
        end

        // Wrong code: one failure, fail pattern, back to idle
        press(4'd1); press(4'd2); press(4'd3); step(1'b1, 4'd5, 1'b0);
        step(1'b0, 4'd5, 1'b0);
        check("fail1_reps", 32'(pat_reps), 32'd3);
        check("fail1_ontime", pat_ontime, 32'd400);
        check("fail1_cnt", 32'(dut.fail_cnt_q), 32'd1);
        step(1'b0, 4'd0, 1'b1);
        check("fail1_idle_cnt", 32'(entry_cnt), 32'd0);
        check("fail1_idle_pen", 32'(pat_enable), 32'd0);

        // Second and third wrong codes -> lockout
        press(4'd9); press(4'd9); press(4'd9); press(4'd9);
        step(1'b0, 4'd0, 1'b1);
        press(4'd1); press(4'd2); press(4'd3); step(1'b1, 4'd5, 1'b0);
        step(1'b0, 4'd5, 1'b0);
        check("lock_alarm", 32'(alarm), 32'd1);
        check("lock_reps", 32'(pat_reps), 32'd255);
        alarm_cycles = 1;
        for (int j = 0; j < LOCKOUT + 10 && alarm; j++) begin
            step(j[0], 4'(code_digit(j % 4)), (j == 5) ? 1'b1 : 1'b0);
            if (alarm) alarm_cycles++;
        end
        check("lockout_len", 32'(alarm_cycles), 32'(LOCKOUT));
        check("lockout_fail_cleared", 32'(dut.fail_cnt_q), 32'd0);
        step(1'b0, 4'd0, 1'b0);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        step(1'b0, 4'd0, 1'b1);
        check("post_lock_unlocked", 32'(unlocked), 32'd1);

        // Automatic relock timing
        open_cycles = 1;
        for (int j = 0; j < RELOCK + 10 && unlocked; j++) begin
            step(1'b0, 4'd0, 1'b0);
            if (unlocked) open_cycles++;
        end
        check("relock_len", 32'(open_cycles), 32'(RELOCK));

        // Clear key, then entry timeout
        press(4'd1); press(4'd2);
        check("clr_before", 32'(entry_cnt), 32'd2);
        press(4'd10);
        check("clr_after", 32'(entry_cnt), 32'd0);
        press(4'd1);
        step(1'b1, 4'd2, 1'b0);
        for (int j = 0; j < ENTRY_TO - 1; j++) step(1'b0, 4'd0, 1'b0);
        check("timeout_edge_hold", 32'(entry_cnt), 32'd2);
        step(1'b0, 4'd0, 1'b0);
        check("timeout_cleared", 32'(entry_cnt), 32'd0);
        check("timeout_fail_cnt", 32'(dut.fail_cnt_q), 32'd0);

        // Key held through reset release is not a press
        do_reset(1'b1);
        step(1'b1, 4'd5, 1'b0);
        step(1'b1, 4'd5, 1'b0);
        check("held_no_digit", 32'(entry_cnt), 32'd0);
        step(1'b0, 4'd5, 1'b0);
        press(4'd1);
        check("after_held_digit", 32'(entry_cnt), 32'd1);
        press(4'd10);

        // Reset in the middle of the success pattern
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("midok_pen", 32'(pat_enable), 32'd1);
        do_reset(1'b0);

        // Randomized traffic against the model
        cur_b = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset(cur_b);
            end else begin
                if (!cur_b) cur_b = ($urandom_range(0, 9) < 6);
                else        cur_b = ($urandom_range(0, 1) == 0);
                r = $urandom_range(0, 9);
                if (r < 5 && m_digits.size() < 4) btn = 4'(code_digit(m_digits.size()));
                else if (r < 8)                   btn = 4'($urandom_range(0, 15));
                else if (r == 8)                  btn = 4'd10;
                else                              btn = 4'd11;
                step(cur_b, btn, ($urandom_range(0, 5) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/keylock_ctrl.md
KEYLOCK_CTRL -- requirements
Module: keylock_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- CODE, 16'h1234, four BCD digits; most-significant nibble is entered first.
- CLK_HZ, 12000000, hwclk frequency used for pattern timings.
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout (range 1..7).
- ENTRY_TIMEOUT, 60000000, idle cycles allowed between digits before the entry is discarded.
- RELOCK_CYC, 120000000, cycles in UNLOCKED before automatic relock.
- LOCKOUT_CYC, 360000000, cycles spent in LOCKOUT.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- hwclk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- button  in  4  key code from the keypad scanner: 0-9 digit, 10 clear, 11 lock, 12-15 invalid.
- bstate  in  1  key-held level from the scanner.
- pat_enable  out  1  request to the LED pattern generator.
- pat_ontime  out  32  pattern on-time in cycles.
- pat_offtime  out  32  pattern off-time in cycles.
- pat_reps  out  8  pattern repetition count.
- pat_done  in  1  pattern-complete indication from the generator.
- unlocked  out  1  lock released.
- alarm  out  1  lockout active.
- entry_cnt  out  3  number of digits entered so far (0..4).

Function
REQ-003 The block SHALL register bstate and SHALL define a key press as a cycle in which bstate is 1 and its registered value is 0; button SHALL be sampled in that same cycle.
REQ-004 The block SHALL implement these FSM states: IDLE, ENTRY, CHECK, SHOW_OK, UNLOCKED, SHOW_FAIL, LOCKOUT.
REQ-005 In IDLE or ENTRY, a digit press SHALL shift the digit into a 16-bit entry register, increment entry_cnt, reset the inactivity timer, and move IDLE to ENTRY.
REQ-006 In IDLE or ENTRY, a clear press (10) SHALL zero the entry register and entry_cnt and go to IDLE.
REQ-007 In IDLE or ENTRY, lock presses (11) and invalid codes (12-15) SHALL be ignored.
REQ-008 In the cycle after entry_cnt reaches 4, the FSM SHALL enter CHECK and SHALL ignore presses until the next return to IDLE; presses SHALL NOT be queued.
REQ-009 If ENTRY_TIMEOUT cycles pass in ENTRY without a press, the block SHALL clear the entry register and entry_cnt and go to IDLE; fail_cnt SHALL NOT change.
REQ-010 CHECK SHALL last exactly one cycle.
- Match with CODE: clear fail_cnt, go to SHOW_OK.
- Mismatch: increment fail_cnt; if the new value equals MAX_FAIL, go to LOCKOUT, otherwise go to SHOW_FAIL.
- In both cases entry_cnt and the entry register SHALL be cleared.
REQ-011 SHOW_OK SHALL drive pat_ontime = pat_offtime = CLK_HZ/4 and pat_reps = 2.
REQ-012 SHOW_FAIL SHALL drive pat_ontime = pat_offtime = CLK_HZ/2 and pat_reps = 3.
REQ-013 LOCKOUT SHALL drive pat_ontime = pat_offtime = CLK_HZ/8 and pat_reps = 255.
REQ-014 In all other states, pat_ontime, pat_offtime and pat_reps SHALL be 0.
REQ-015 Pattern handshake:
- pat_enable SHALL rise in the first cycle of SHOW_OK, SHOW_FAIL or LOCKOUT.
- pat_enable SHALL stay high, with constant pattern values, until pat_done is sampled high.
- pat_enable SHALL be low in the following cycle.
- pat_done SHALL be ignored while pat_enable is low.
REQ-016 On pat_done, SHOW_OK SHALL go to UNLOCKED and SHOW_FAIL SHALL go to IDLE.
REQ-017 UNLOCKED SHALL drive unlocked = 1.
- A lock press SHALL go to IDLE.
- After RELOCK_CYC cycles with no lock press, the FSM SHALL go to IDLE.
- Other presses SHALL be ignored.
REQ-018 LOCKOUT SHALL drive alarm = 1 and ignore all presses.
- After LOCKOUT_CYC cycles, it SHALL clear fail_cnt and go to IDLE, regardless of pat_done.
- pat_done in LOCKOUT SHALL only drop pat_enable.
REQ-019 All timers SHALL be 32-bit, SHALL reload to 0 on state entry, and SHALL saturate without wrapping.
REQ-020 unlocked, alarm and entry_cnt SHALL be registered outputs.

Reset
REQ-021 While rst = 1, the block SHALL asynchronously force:
- FSM to IDLE;
- entry register, entry_cnt, fail_cnt and all timers to 0;
- pat_enable, unlocked and alarm to 0;
- pattern outputs to 0;
- registered bstate to 1, so that a key held through reset is not counted.
REQ-022 Reset asserted in any state, including during a pattern handshake, SHALL abort that state without waiting for pat_done.

Verification
REQ-023 The bench SHALL cover these directed scenarios, using small timing parameters:
- Press 1,2,3,4 -> CHECK one cycle after the 4th press, then pat_enable=1 with reps=2 and on/off=CLK_HZ/4; pulse pat_done -> unlocked=1 next cycle; press 11 -> unlocked=0.
- Press 1,2,3,5 -> SHOW_FAIL with reps=3, fail_cnt=1; pat_done -> IDLE, entry_cnt=0.
- Three wrong codes -> third CHECK enters LOCKOUT with alarm=1; presses ignored; after LOCKOUT_CYC -> alarm=0; a correct code then unlocks.
- Press 1,2, then 10 -> entry_cnt=0; press 1,2, then idle ENTRY_TIMEOUT cycles -> entry_cnt=0 and fail_cnt unchanged.
- Hold bstate across a rst release -> no digit accepted; assert rst mid-SHOW_OK -> pat_enable=0 immediately.
- In UNLOCKED with no press -> auto relock after exactly RELOCK_CYC cycles.
